// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive control stage of the UART receiver. Synchronizes the raw serial
// line, detects the start of a frame, runs the external bit timer, shifts in
// 8 data bits (LSB first) plus the stop bit on the timer's shift_enable
// pulses, checks framing and holds the received byte in a one-deep output
// buffer with a ready/read handshake and an overrun flag.
//
// Ports:
//   clk           in   system clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   serial_in     in   raw UART line (asynchronous, idles high)
//   shift_enable  in   timer pulse at the middle of each bit
//   packet_done   in   timer pulse after the 9th shift_enable
//   enable_timer  out  runs the bit timer; low also clears it
//   data_read     in   consumer acknowledge of the buffered byte
//   rx_data       out  last good received byte
//   data_ready    out  rx_data holds an unread byte
//   overrun_error out  an unread byte was overwritten
//   framing_error out  stop bit of the last frame sampled 0
//
// Build option:
//   UART_RX_GLITCH_FILTER_EN  when defined, a start requires the synchronized
//   line to be low for 3 consecutive clocks after a high, so shorter pulses
//   are rejected (start latency 5 clocks instead of 3).
// ---------------------------------------------------------------------------
module uart_rx_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  input  logic       shift_enable,
  input  logic       packet_done,
  output logic       enable_timer,
  input  logic       data_read,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       overrun_error,
  output logic       framing_error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RECEIVE = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] LOAD    = 2'd3;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       sync_1;
  logic       line;
  logic       start_cond;
  logic [8:0] sr;

  // Two-flop synchronizer; both stages reset to the idle (high) level so
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_1 <= 1'b1;
      line   <= 1'b1;
    end else begin
      sync_1 <= serial_in;
      line   <= sync_1;
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic [1:0] low_cnt;

  // Counts consecutive low clocks of the synchronized line, saturating at 3
  // so a line held low (break) cannot retrigger a start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      low_cnt <= 2'd0;
    end else if (line) begin
      low_cnt <= 2'd0;
    end else if (low_cnt != 2'd3) begin
      low_cnt <= low_cnt + 2'd1;
    end
  end

  // Third consecutive low clock: two lows already counted and line still low.
  assign start_cond = !line && (low_cnt == 2'd2);
`else
  logic line_d;

  // Delayed copy of the synchronized line for falling-edge detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line_d <= 1'b1;
    end else begin
      line_d <= line;
    end
  end

  assign start_cond = line_d && !line;
`endif

  // Next-state logic. Timer pulses only matter in RECEIVE and start
  // conditions only in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_cond) next_state = RECEIVE;
      RECEIVE: if (packet_done) next_state = CHECK;
      CHECK:   next_state = sr[8] ? LOAD : IDLE;
      LOAD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; enable_timer is registered from the next state so it
  // is a clean flop output that is high exactly while in RECEIVE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      enable_timer <= 1'b0;
    end else begin
      state        <= next_state;
      enable_timer <= (next_state == RECEIVE);
    end
  end

  // Shift register: preset to all ones at the start of a frame, then shifts
  // right so the first sampled bit ends in sr[0] and the stop bit in sr[8].
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr <= 9'h1FF;
    end else if (state == IDLE && start_cond) begin
      sr <= 9'h1FF;
    end else if (state == RECEIVE && shift_enable) begin
      sr <= {line, sr[8:1]};
    end
  end

  // Framing flag is cleared when a new frame starts and set when the stop
  // bit of a frame is found low.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      framing_error <= 1'b0;
    end else if (state == IDLE && start_cond) begin
      framing_error <= 1'b0;
    end else if (state == CHECK && !sr[8]) begin
      framing_error <= 1'b1;
    end
  end

  // Output buffer. In LOAD the new byte always wins over a simultaneous
  // read: data_ready stays set, and a read in that cycle counts as having
  // consumed the old byte so overrun is cleared rather than set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= 8'h00;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else if (state == LOAD) begin
      rx_data    <= sr[7:0];
      data_ready <= 1'b1;
      if (data_read) begin
        overrun_error <= 1'b0;
      end else if (data_ready) begin
        overrun_error <= 1'b1;
      end
    end else if (data_read) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Directed bench for uart_rx_ctrl. Contains a 10-clock-per-bit timer model
// driven by enable_timer, sends frames on serial_in (changing on falling
// clock edges) and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int START_LAT = 5;
`else
  localparam int START_LAT = 3;
`endif
  // Falling edge (counted from the start-bit edge) that precedes the LOAD
  // cycle: stop bit sampled at edge 11+START_LAT+80, then CHECK, LOAD.
  localparam int LOAD_NEG = 93 + START_LAT;

  logic       clk;
  logic       n_rst;
  logic       serial_in;
  logic       shift_enable;
  logic       packet_done;
  logic       enable_timer;
  logic       data_read;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;

  int checks;
  int errors;

  logic [3:0] tmr_cnt;
  logic [3:0] tmr_shifts;

  uart_rx_ctrl dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .shift_enable  (shift_enable),
    .packet_done   (packet_done),
    .enable_timer  (enable_timer),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit timer model: shift_enable every 10 enabled clocks, packet_done the
  // clock after the 9th shift_enable; held clear while enable_timer is low.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmr_cnt      <= 4'd0;
      tmr_shifts   <= 4'd0;
      shift_enable <= 1'b0;
      packet_done  <= 1'b0;
    end else if (!enable_timer) begin
      tmr_cnt      <= 4'd0;
      tmr_shifts   <= 4'd0;
      shift_enable <= 1'b0;
      packet_done  <= 1'b0;
    end else begin
      packet_done <= shift_enable && (tmr_shifts == 4'd9);
      if (tmr_cnt == 4'd9) begin
        tmr_cnt      <= 4'd0;
        shift_enable <= 1'b1;
        tmr_shifts   <= tmr_shifts + 4'd1;
      end else begin
        tmr_cnt      <= tmr_cnt + 4'd1;
        shift_enable <= 1'b0;
      end
    end
  end

  // Single comparison point for every check in the bench.
  task automatic check_output(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] exp_data,
                           input logic exp_ready, input logic exp_ovr,
                           input logic exp_fe);
    check_output({tag, "_rx_data"}, {8'h00, rx_data}, {8'h00, exp_data});
    check_output({tag, "_data_ready"}, {15'd0, data_ready}, {15'd0, exp_ready});
    check_output({tag, "_overrun"}, {15'd0, overrun_error}, {15'd0, exp_ovr});
    check_output({tag, "_framing"}, {15'd0, framing_error}, {15'd0, exp_fe});
  endtask

  // Drives up to 'limit' falling-edge bit slots of a frame (100 = full
  // frame). Checks start latency on the way; optionally pulses data_read in
  // the LOAD cycle.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop,
                                input bit read_in_load, input int limit);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (i == START_LAT - 1)
        check_output("enable_before_start", {15'd0, enable_timer}, 16'd0);
      if (i == START_LAT) begin
        check_output("enable_at_start", {15'd0, enable_timer}, 16'd1);
        check_output("framing_clear_at_start", {15'd0, framing_error}, 16'd0);
      end
      serial_in = bits[i / 10];
      data_read = read_in_load && (i == LOAD_NEG);
    end
    if (limit >= 100) begin
      repeat (4) begin
        @(negedge clk);
        serial_in = 1'b1;
        data_read = 1'b0;
      end
    end
  endtask

  task automatic read_pulse();
    @(negedge clk);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    n_rst        = 1'b0;
    serial_in    = 1'b1;
    data_read    = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check_output("reset_enable", {15'd0, enable_timer}, 16'd0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // Good frame
    apply_stimulus(8'h5A, 1'b1, 1'b0, 100);
    check_all("good_5a", 8'h5A, 1'b1, 1'b0, 1'b0);
    check_output("good_enable_low", {15'd0, enable_timer}, 16'd0);
    read_pulse();
    check_all("read_5a", 8'h5A, 1'b0, 1'b0, 1'b0);
    read_pulse();
    check_all("read_when_empty", 8'h5A, 1'b0, 1'b0, 1'b0);

    // Framing error, then a good frame clears it
    apply_stimulus(8'hC3, 1'b0, 1'b0, 100);
    check_all("framing_c3", 8'h5A, 1'b0, 1'b0, 1'b1);
    apply_stimulus(8'h11, 1'b1, 1'b0, 100);
    check_all("good_11", 8'h11, 1'b1, 1'b0, 1'b0);
    read_pulse();
    check_all("read_11", 8'h11, 1'b0, 1'b0, 1'b0);

    // Overrun
    apply_stimulus(8'h01, 1'b1, 1'b0, 100);
    check_all("ovr_first", 8'h01, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'h02, 1'b1, 1'b0, 100);
    check_all("ovr_second", 8'h02, 1'b1, 1'b1, 1'b0);
    read_pulse();
    check_all("ovr_read", 8'h02, 1'b0, 1'b0, 1'b0);

    // Read exactly in the LOAD cycle while an unread byte is buffered
    apply_stimulus(8'h33, 1'b1, 1'b0, 100);
    check_all("pre_load_read", 8'h33, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'h7E, 1'b1, 1'b1, 100);
    check_all("read_in_load", 8'h7E, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a frame, after 4 data bits
    apply_stimulus(8'h3C, 1'b1, 1'b0, 50);
    check_output("midframe_enable", {15'd0, enable_timer}, 16'd1);
    #2;
    n_rst = 1'b0;
    #1;
    check_all("midframe_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check_output("midframe_reset_enable", {15'd0, enable_timer}, 16'd0);
    @(negedge clk);
    serial_in = 1'b1;
    n_rst     = 1'b1;
    repeat (4) @(negedge clk);
    apply_stimulus(8'hA5, 1'b1, 1'b0, 100);
    check_all("after_reset_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    read_pulse();
    repeat (4) @(negedge clk);

    // Two-clock low glitch on the idle line
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
`ifdef UART_RX_GLITCH_FILTER_EN
      if (i == 2 || i == 3 || i == 5 || i == 8)
        check_output("glitch_enable", {15'd0, enable_timer}, 16'd0);
`else
      if (i == 2)
        check_output("glitch_enable_before", {15'd0, enable_timer}, 16'd0);
      if (i == 3 || i == 5 || i == 8)
        check_output("glitch_enable_after", {15'd0, enable_timer}, 16'd1);
`endif
      serial_in = (i < 2) ? 1'b0 : 1'b1;
    end
    repeat (110) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
